// File: rtl/pim_dma_ctrl_if.sv
// -----------------------------------------------------------------------------
// pim_dma_ctrl_if
//   Bundles every non-clock signal of the PIM DMA controller: the PIM command
//   strobe and operands, the core's DMEM request port, the shared DMEM port
//   and the word stream towards the PIM accelerator.
//
//   modport master : the DMA controller itself
//   modport slave  : its environment (decoder, core LSU, DMEM, PIM)
//
//   Command  : dma_en_i, cmd_src_i, cmd_dst_i, cmd_len_i -> busy_o, done_o, stall_o
//   Core     : core_req_i, core_we_i, core_addr_i, core_wdata_i, core_be_i
//              -> core_gnt_o, core_rdata_o
//   DMEM     : dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o
//              <- dmem_rdata_i (one cycle after a read request)
//   PIM      : pim_valid_o, pim_addr_o, pim_data_o <- pim_ready_i
// -----------------------------------------------------------------------------
interface pim_dma_ctrl_if #(
  parameter int LEN_W = 16
);
  // Command from the decoder
  logic             dma_en_i;
  logic [31:0]      cmd_src_i;
  logic [31:0]      cmd_dst_i;
  logic [LEN_W-1:0] cmd_len_i;
  logic             busy_o;
  logic             done_o;
  logic             stall_o;

  // Core load/store port
  logic             core_req_i;
  logic             core_we_i;
  logic [31:0]      core_addr_i;
  logic [31:0]      core_wdata_i;
  logic [3:0]       core_be_i;
  logic             core_gnt_o;
  logic [31:0]      core_rdata_o;

  // Shared DMEM port
  logic             dmem_req_o;
  logic             dmem_we_o;
  logic [31:0]      dmem_addr_o;
  logic [31:0]      dmem_wdata_o;
  logic [3:0]       dmem_be_o;
  logic [31:0]      dmem_rdata_i;

  // Word stream to the PIM accelerator
  logic             pim_valid_o;
  logic             pim_ready_i;
  logic [31:0]      pim_addr_o;
  logic [31:0]      pim_data_o;

  modport master (
    input  dma_en_i, cmd_src_i, cmd_dst_i, cmd_len_i,
    output busy_o, done_o, stall_o,
    input  core_req_i, core_we_i, core_addr_i, core_wdata_i, core_be_i,
    output core_gnt_o, core_rdata_o,
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o,
    input  dmem_rdata_i,
    output pim_valid_o, pim_addr_o, pim_data_o,
    input  pim_ready_i
  );

  modport slave (
    output dma_en_i, cmd_src_i, cmd_dst_i, cmd_len_i,
    input  busy_o, done_o, stall_o,
    output core_req_i, core_we_i, core_addr_i, core_wdata_i, core_be_i,
    input  core_gnt_o, core_rdata_o,
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o,
    output dmem_rdata_i,
    input  pim_valid_o, pim_addr_o, pim_data_o,
    output pim_ready_i
  );
endinterface

// File: rtl/pim_dma_ctrl.sv
// -----------------------------------------------------------------------------
// pim_dma_ctrl
//   Background DMA for the PIM offload path. A PIM command latches a DMEM
//   source, a PIM destination and a word count; the block then moves one word
//   at a time: read DMEM (RD), capture the read data (WAIT), hand the word to
//   the PIM accelerator (PUSH). The single DMEM port is shared with the core:
//   the core wins the port in RD, except after STARVE_LIM consecutive wins,
//   when the DMA takes it for one cycle.
//
//   Parameters : STARVE_LIM - consecutive denied DMA read cycles tolerated (>=1)
//                LEN_W      - width of the transfer length in words
//   Ports      : clk_i - rising-edge clock
//                rst_i - synchronous, active-high reset (aborts any transfer)
//                bus   - pim_dma_ctrl_if.master (command, core, DMEM, PIM)
// -----------------------------------------------------------------------------
module pim_dma_ctrl #(
  parameter int STARVE_LIM = 4,
  parameter int LEN_W      = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  pim_dma_ctrl_if.master bus
);

  localparam int              SC_W       = $clog2(STARVE_LIM + 1);
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIM);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_PUSH,
    S_DONE
  } state_e;

  state_e           state_q,  state_d;
  logic [31:0]      src_q,    src_d;
  logic [31:0]      dst_q,    dst_d;
  logic [31:0]      buf_q,    buf_d;
  logic [LEN_W-1:0] rem_q,    rem_d;
  logic [SC_W-1:0]  starve_q, starve_d;

  // Arbitration: in RD the core keeps the port until the DMA has been denied
  // STARVE_LIM times in a row; outside RD the DMA never touches the port.
  logic core_wins;
  logic dma_issue;
  logic core_gnt;

  assign core_wins = bus.core_req_i && (starve_q < STARVE_MAX);
  assign dma_issue = (state_q == S_RD) && !core_wins;
  assign core_gnt  = !(dma_issue && bus.core_req_i);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every *_d gets its hold value first so no path through the case
    // leaves a variable unassigned (which would infer a latch).
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    buf_d    = buf_q;
    rem_d    = rem_q;
    starve_d = starve_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.dma_en_i) begin
          src_d    = bus.cmd_src_i & ~32'h3;
          dst_d    = bus.cmd_dst_i & ~32'h3;
          rem_d    = bus.cmd_len_i;
          starve_d = '0;
          state_d  = (bus.cmd_len_i == '0) ? S_DONE : S_RD;
        end
      end

      S_RD: begin
        if (core_wins) begin
          starve_d = starve_q + SC_W'(1);
        end else begin
          starve_d = '0;
          state_d  = S_WAIT;
        end
      end

      S_WAIT: begin
        buf_d   = bus.dmem_rdata_i;
        state_d = S_PUSH;
      end

      S_PUSH: begin
        if (bus.pim_ready_i) begin
          src_d   = src_q + 32'd4;
          dst_d   = dst_q + 32'd4;
          rem_d   = rem_q - LEN_W'(1);
          state_d = (rem_q == LEN_W'(1)) ? S_DONE : S_RD;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    // NOTE: all registers, including the data buffer, are cleared so a reset
    // mid-transfer leaves nothing of the aborted transfer visible.
    if (rst_i) begin
      state_q  <= S_IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      buf_q    <= '0;
      rem_q    <= '0;
      starve_q <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge *_d values.
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      buf_q    <= buf_d;
      rem_q    <= rem_d;
      starve_q <= starve_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (combinational from state, registers and the core request)
  // ---------------------------------------------------------------------------
  assign bus.busy_o       = (state_q != S_IDLE);
  assign bus.done_o       = (state_q == S_DONE);
  assign bus.stall_o      = bus.dma_en_i && (state_q != S_IDLE);
  assign bus.core_gnt_o   = core_gnt;
  assign bus.core_rdata_o = bus.dmem_rdata_i;

  // DMEM mux: the DMA read when it wins, otherwise the core untouched. With no
  // requester the port is driven to zero.
  always_comb begin
    bus.dmem_req_o   = dma_issue || (bus.core_req_i && core_gnt);
    bus.dmem_we_o    = 1'b0;
    bus.dmem_addr_o  = '0;
    bus.dmem_wdata_o = '0;
    bus.dmem_be_o    = '0;
    if (dma_issue) begin
      bus.dmem_addr_o = src_q;
      bus.dmem_be_o   = 4'b1111;
    end else if (bus.core_req_i) begin
      bus.dmem_we_o    = bus.core_we_i;
      bus.dmem_addr_o  = bus.core_addr_i;
      bus.dmem_wdata_o = bus.core_wdata_i;
      bus.dmem_be_o    = bus.core_be_i;
    end
  end

  // PIM word is held by registers alone, so it is stable under backpressure.
  assign bus.pim_valid_o = (state_q == S_PUSH);
  assign bus.pim_addr_o  = (state_q == S_PUSH) ? dst_q : '0;
  assign bus.pim_data_o  = (state_q == S_PUSH) ? buf_q : '0;

endmodule

// File: tb/tb_pim_dma_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pim_dma_ctrl
//   Bench for pim_dma_ctrl. A transaction-level model turns each accepted
//   command into the list of DMEM reads and PIM words it owes, and tracks the
//   timing rules (read deferred only by core wins, bounded by STARVE_LIM; word
//   offered two cycles after its read; done right after the last handshake).
//   Directed scenarios pin exact cycle timelines, then randomized traffic runs.
// -----------------------------------------------------------------------------
module tb_pim_dma_ctrl;

  localparam int LIM = 4;
  localparam int LW  = 16;

  logic clk = 1'b0;
  logic rst;
  logic mem_init;

  always #5 clk = ~clk;

  pim_dma_ctrl_if #(.LEN_W(LW)) bus ();

  pim_dma_ctrl #(
    .STARVE_LIM (LIM),
    .LEN_W      (LW)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.master)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // DMEM: 256 words, aliased on address bits [9:2], one-cycle read latency.
  // Words 64..66 (byte 0x100..0x108) hold 0xA0..0xA2.
  // ---------------------------------------------------------------------------
  logic [31:0] mem [0:255];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem[a[9:2]];
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++)
        mem[i] <= (i >= 64 && i <= 66) ? 32'hA0 + 32'(i - 64)
                                       : (32'(i) * 32'h0100_0193) ^ 32'h5A5A_0000;
    end else if (bus.dmem_req_o === 1'b1) begin
      if (bus.dmem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (bus.dmem_be_o[b]) mem[bus.dmem_addr_o[9:2]][8*b +: 8] <= bus.dmem_wdata_o[8*b +: 8];
      end else begin
        bus.dmem_rdata_i <= mem_rd(bus.dmem_addr_o);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  bit          model_ok = 1'b0;
  bit          m_busy, m_done, m_rd_due;
  int          m_deny, m_push_wait, m_left;
  logic [31:0] rd_q[$];   // DMEM addresses still to be read
  logic [31:0] dst_q[$];  // PIM addresses still to be delivered
  logic [31:0] dat_q[$];  // words read but not yet delivered
  bit          m_rd_now, m_gnt, m_valid, m_hs, m_acc, m_was_rd;

  task automatic model_clear();
    m_busy = 0; m_done = 0; m_rd_due = 0; m_deny = 0; m_push_wait = -1; m_left = 0;
    rd_q.delete(); dst_q.delete(); dat_q.delete();
  endtask

  always @(negedge clk) begin
    if (model_ok) begin
      m_rd_now = m_rd_due && !(bus.core_req_i && m_deny < LIM);
      m_gnt    = !(m_rd_now && bus.core_req_i);
      m_valid  = (m_push_wait == 0);
      m_hs     = m_valid && bus.pim_ready_i;
      m_acc    = !m_busy && bus.dma_en_i;
      m_was_rd = m_rd_due;

      check("busy",       bus.busy_o,       m_busy);
      check("done",       bus.done_o,       m_done);
      check("stall",      bus.stall_o,      bus.dma_en_i && m_busy);
      check("core_gnt",   bus.core_gnt_o,   m_gnt);
      check("dmem_req",   bus.dmem_req_o,   bus.core_req_i || m_rd_now);
      check("core_rdata", bus.core_rdata_o, bus.dmem_rdata_i);
      check("pim_valid",  bus.pim_valid_o,  m_valid);
      if (m_rd_now) begin
        check("dma_addr", bus.dmem_addr_o, rd_q[0]);
        check("dma_we",   bus.dmem_we_o,   1'b0);
        check("dma_be",   bus.dmem_be_o,   4'b1111);
      end else if (bus.core_req_i) begin
        check("core_addr",  bus.dmem_addr_o,  bus.core_addr_i);
        check("core_we",    bus.dmem_we_o,    bus.core_we_i);
        check("core_be",    bus.dmem_be_o,    bus.core_be_i);
        check("core_wdata", bus.dmem_wdata_o, bus.core_wdata_i);
      end
      if (m_valid) begin
        check("pim_addr", bus.pim_addr_o, dst_q[0]);
        check("pim_data", bus.pim_data_o, dat_q[0]);
      end

      // Advance to the next cycle.
      if (m_done) begin
        m_busy = 0;
        m_done = 0;
      end
      if (m_push_wait == 1) begin
        m_push_wait = 0;
      end else if (m_hs) begin
        void'(dst_q.pop_front());
        void'(dat_q.pop_front());
        m_left--;
        m_push_wait = -1;
        if (m_left == 0) m_done = 1;
        else             m_rd_due = 1;
      end
      if (m_rd_now) begin
        dat_q.push_back(mem_rd(rd_q[0]));
        void'(rd_q.pop_front());
        m_rd_due    = 0;
        m_deny      = 0;
        m_push_wait = 1;
      end else if (m_was_rd) begin
        m_deny++;
      end
      if (m_acc) begin
        m_busy = 1;
        m_left = int'(bus.cmd_len_i);
        for (int i = 0; i < m_left; i++) begin
          rd_q.push_back((bus.cmd_src_i & ~32'h3) + 32'(4 * i));
          dst_q.push_back((bus.cmd_dst_i & ~32'h3) + 32'(4 * i));
        end
        if (m_left == 0) m_done = 1;
        else begin
          m_rd_due = 1;
          m_deny   = 0;
        end
      end
    end
    if (rst) begin
      model_clear();
      model_ok = 1;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after posedge, checks at negedge
  // ---------------------------------------------------------------------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.dma_en_i     = 1'b0;
    bus.cmd_src_i    = '0;
    bus.cmd_dst_i    = '0;
    bus.cmd_len_i    = '0;
    bus.core_req_i   = 1'b0;
    bus.core_we_i    = 1'b0;
    bus.core_addr_i  = '0;
    bus.core_wdata_i = '0;
    bus.core_be_i    = '0;
    bus.pim_ready_i  = 1'b1;
    rst              = 1'b0;
  endtask

  // Issues a command in cycle N and returns at the start of cycle N+1.
  task automatic issue(input logic [31:0] src, input logic [31:0] dst, input int len);
    bus.dma_en_i  = 1'b1;
    bus.cmd_src_i = src;
    bus.cmd_dst_i = dst;
    bus.cmd_len_i = LW'(len);
    sample();
    check("issue_idle", bus.busy_o, 1'b0);
    next_cycle();
    bus.dma_en_i = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"},       bus.busy_o,       1'b0);
    check({tag, "_done"},       bus.done_o,       1'b0);
    check({tag, "_stall"},      bus.stall_o,      1'b0);
    check({tag, "_pim_valid"},  bus.pim_valid_o,  1'b0);
    check({tag, "_dmem_req"},   bus.dmem_req_o,   1'b0);
    check({tag, "_dmem_we"},    bus.dmem_we_o,    1'b0);
    check({tag, "_pim_addr"},   bus.pim_addr_o,   32'h0);
    check({tag, "_pim_data"},   bus.pim_data_o,   32'h0);
    check({tag, "_dmem_addr"},  bus.dmem_addr_o,  32'h0);
    check({tag, "_dmem_wdata"}, bus.dmem_wdata_o, 32'h0);
    check({tag, "_dmem_be"},    bus.dmem_be_o,    4'h0);
    check({tag, "_core_gnt"},   bus.core_gnt_o,   1'b1);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    idle_inputs();
    rst      = 1'b1;
    mem_init = 1'b1;
    next_cycle();
    next_cycle();
    rst      = 1'b0;
    mem_init = 1'b0;
    sample();
    check_reset_values("por");
    next_cycle();

    // Uncontended: src 0x100, dst 0x40, len 3
    issue(32'h100, 32'h40, 3);
    for (int k = 1; k <= 11; k++) begin
      sample();
      check("uc_req", bus.dmem_req_o, (k == 1 || k == 4 || k == 7));
      if (k == 1 || k == 4 || k == 7)
        check("uc_rd_addr", bus.dmem_addr_o, 32'h100 + 32'(4 * ((k - 1) / 3)));
      check("uc_valid", bus.pim_valid_o, (k == 3 || k == 6 || k == 9));
      if (k == 3 || k == 6 || k == 9) begin
        check("uc_pim_addr", bus.pim_addr_o, 32'h40 + 32'(4 * (k / 3 - 1)));
        check("uc_pim_data", bus.pim_data_o, 32'hA0 + 32'(k / 3 - 1));
      end
      check("uc_done", bus.done_o, k == 10);
      check("uc_busy", bus.busy_o, k <= 10);
      next_cycle();
    end

    // Zero length
    issue(32'h200, 32'h80, 0);
    for (int k = 1; k <= 2; k++) begin
      sample();
      check("z_done",  bus.done_o,      k == 1);
      check("z_busy",  bus.busy_o,      k == 1);
      check("z_req",   bus.dmem_req_o,  1'b0);
      check("z_valid", bus.pim_valid_o, 1'b0);
      next_cycle();
    end

    // Starvation guard: core requests every cycle, len 1
    bus.core_req_i  = 1'b1;
    bus.core_addr_i = 32'h300;
    bus.core_be_i   = 4'b1111;
    issue(32'h180, 32'hC0, 1);
    for (int k = 1; k <= 8; k++) begin
      sample();
      check("sg_gnt",  bus.core_gnt_o,  k != 5);
      check("sg_req",  bus.dmem_req_o,  1'b1);
      check("sg_addr", bus.dmem_addr_o, (k == 5) ? 32'h180 : 32'h300);
      check("sg_done", bus.done_o,      k == 8);
      next_cycle();
    end
    idle_inputs();

    // PIM backpressure: ready low for 5 PUSH cycles
    issue(32'h104, 32'h50, 1);
    for (int k = 1; k <= 10; k++) begin
      bus.pim_ready_i = !(k >= 3 && k <= 7);
      sample();
      check("bp_valid", bus.pim_valid_o, (k >= 3 && k <= 8));
      if (k >= 3 && k <= 8) begin
        check("bp_addr", bus.pim_addr_o, 32'h50);
        check("bp_data", bus.pim_data_o, 32'hA1);
      end
      check("bp_done", bus.done_o, k == 9);
      next_cycle();
    end
    idle_inputs();

    // Command while busy: second command held from N+2
    issue(32'h100, 32'h10, 2);
    for (int k = 1; k <= 13; k++) begin
      bus.dma_en_i  = (k >= 2 && k <= 8);
      bus.cmd_src_i = 32'h10B;
      bus.cmd_dst_i = 32'h23;
      bus.cmd_len_i = LW'(1);
      sample();
      check("cb_stall", bus.stall_o, (k >= 2 && k <= 7));
      check("cb_busy",  bus.busy_o,  k != 8 && k != 13);
      check("cb_done",  bus.done_o,  k == 7 || k == 12);
      if (k == 9) check("cb_rd_addr", bus.dmem_addr_o, 32'h108);
      if (k == 11) begin
        check("cb_pim_addr", bus.pim_addr_o, 32'h20);
        check("cb_pim_data", bus.pim_data_o, 32'hA2);
      end
      next_cycle();
    end
    idle_inputs();

    // Reset during the PUSH of word 2 of 4
    issue(32'h100, 32'h60, 4);
    for (int k = 1; k <= 12; k++) begin
      rst = (k == 6);
      sample();
      if (k == 6) begin
        check("rs_valid",    bus.pim_valid_o, 1'b1);
        check("rs_pim_addr", bus.pim_addr_o,  32'h64);
        check("rs_pim_data", bus.pim_data_o,  32'hA1);
      end
      if (k == 7) check_reset_values("rs");
      if (k >= 7) check("rs_no_done", bus.done_o, 1'b0);
      next_cycle();
    end
    rst = 1'b0;
    issue(32'h108, 32'h70, 1);
    for (int k = 1; k <= 4; k++) begin
      sample();
      if (k == 1) check("rs2_rd_addr", bus.dmem_addr_o, 32'h108);
      if (k == 3) begin
        check("rs2_pim_addr", bus.pim_addr_o, 32'h70);
        check("rs2_pim_data", bus.pim_data_o, 32'hA2);
      end
      check("rs2_done", bus.done_o, k == 4);
      next_cycle();
    end

    // Address wrap
    issue(32'hFFFF_FFFC, 32'h0, 2);
    for (int k = 1; k <= 7; k++) begin
      sample();
      if (k == 1) check("wr_rd0", bus.dmem_addr_o, 32'hFFFF_FFFC);
      if (k == 4) check("wr_rd1", bus.dmem_addr_o, 32'h0000_0000);
      if (k == 6) check("wr_pim1", bus.pim_addr_o, 32'h4);
      check("wr_done", bus.done_o, k == 7);
      next_cycle();
    end

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      bit burst;
      burst            = ((c / 64) % 3) == 1;
      rst              = ($urandom_range(0, 499) == 0);
      bus.dma_en_i     = ($urandom_range(0, 5) == 0);
      bus.cmd_src_i    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15))
                                                     : $urandom;
      bus.cmd_dst_i    = $urandom;
      bus.cmd_len_i    = LW'($urandom_range(0, 5));
      bus.core_req_i   = burst ? 1'b1 : 1'($urandom_range(0, 1));
      bus.core_we_i    = ($urandom_range(0, 2) == 0);
      bus.core_addr_i  = $urandom & ~32'h3;
      bus.core_wdata_i = $urandom;
      case ($urandom_range(0, 2))
        0:       bus.core_be_i = 4'b0001;
        1:       bus.core_be_i = 4'b0011;
        default: bus.core_be_i = 4'b1111;
      endcase
      bus.pim_ready_i  = ($urandom_range(0, 2) != 0);
      next_cycle();
    end

    // Drain with a bounded wait
    idle_inputs();
    for (int c = 0; c < 200; c++) begin
      sample();
      if (bus.busy_o === 1'b0) break;
      next_cycle();
    end
    check("drain_idle", bus.busy_o, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pim_dma_ctrl.md
# pim_dma_ctrl

Background DMA controller for the PIM offload path. When the core issues a PIM instruction, this block accepts the source, destination and length, then streams words from data memory to the PIM accelerator. It shares the single DMEM port with the core's load/store traffic using core-priority arbitration with a starvation guard, and stalls the core only on port loss or on a second PIM command while busy.

## Interface
- STARVE_LIM, 4: consecutive denied DMA read cycles before the DMA wins the DMEM port (≥1)
- LEN_W, 16: width of the transfer length in words
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous reset, active-high
- dma_en_i  in  1  PIM command strobe from the decoder
- cmd_src_i  in  32  DMEM source byte address; bits [1:0] ignored
- cmd_dst_i  in  32  PIM destination byte address; bits [1:0] ignored
- cmd_len_i  in  LEN_W  transfer length in words
- busy_o  out  1  transfer in progress
- done_o  out  1  one-cycle completion pulse
- stall_o  out  1  core must hold its PIM instruction (command not accepted)
- core_req_i  in  1  core DMEM access this cycle (mem_read or mem_write)
- core_we_i  in  1  core write
- core_addr_i  in  32  core address
- core_wdata_i  in  32  core write data
- core_be_i  in  4  core byte enables (d_size encoding 0001/0011/1111)
- core_gnt_o  out  1  core access issued this cycle; core stalls if req && !gnt
- core_rdata_o  out  32  equals dmem_rdata_i
- dmem_req_o, dmem_we_o  out  1  DMEM request, write enable
- dmem_addr_o  out  32  DMEM address
- dmem_wdata_o  out  32  DMEM write data
- dmem_be_o  out  4  DMEM byte enables
- dmem_rdata_i  in  32  DMEM read data, valid the cycle after the read request
- pim_valid_o  out  1  word valid to PIM
- pim_ready_i  in  1  PIM accepts word
- pim_addr_o  out  32  PIM word address
- pim_data_o  out  32  PIM word data

## Operation
- States: IDLE, RD, WAIT, PUSH, DONE.
- IDLE: on dma_en_i, latch src/dst with [1:0] forced to 0, and latch len into rem. If len==0, go to DONE. Otherwise go to RD.
- RD: DMA requests a read at src with be=1111 and we=0.
  - Core wins if core_req_i and starve_cnt<STARVE_LIM. In that case starve_cnt++ and the state stays RD.
  - Otherwise the DMA read is issued, starve_cnt clears, and the state goes to WAIT.
- WAIT: capture dmem_rdata_i into buf, then go to PUSH. The DMEM port is free for the core.
- PUSH: drive pim_valid_o=1 with pim_addr_o=dst and pim_data_o=buf. Address and data stay stable until pim_ready_i.
  - On the handshake: src+=4, dst+=4 (mod 2^32 wrap), rem-=1.
  - Then go to DONE if rem was 1, else to RD.
- DONE: done_o=1, then go to IDLE.
- Arbitration: the core is passed through unchanged when granted. core_gnt_o=0 only in an RD cycle where the DMA wins while core_req_i=1. In every other cycle core_gnt_o=1.
- dmem_req_o is the OR of the core grant (with core_req_i) and the DMA issue.
- stall_o = dma_en_i && state!=IDLE. A command is accepted only in IDLE. dma_en_i during DONE is accepted the following cycle.
- busy_o = state!=IDLE (high in DONE).
- Reset: all state cleared and FSM to IDLE. Any in-flight transfer is aborted silently, with no done_o.

## Timing
- Reset values: busy_o, done_o, stall_o, pim_valid_o, dmem_req_o, dmem_we_o = 0. pim_addr_o, pim_data_o, dmem_addr_o, dmem_wdata_o, dmem_be_o = 0. core_gnt_o = 1.
- Command accepted at cycle N (IDLE && dma_en_i). First RD is at N+1.
- Uncontended, with pim_ready_i=1, each word takes 3 cycles (RD, WAIT, PUSH).
- done_o is at cycle N+1+3·len. For len=0, done_o is at N+1.
- Each cycle of core win adds 1 cycle. Each cycle of pim_ready_i=0 in PUSH adds 1 cycle.
- The DMA is denied at most STARVE_LIM consecutive RD cycles.
- All outputs are combinational from state and registers. There are no combinational paths from pim_ready_i to DMEM outputs.

## Test plan
- Uncontended transfer:
  - Stimulus: src=0x100, dst=0x40, len=3 accepted at N, DMEM holds 0xA0,0xA1,0xA2, pim_ready_i=1.
  - Response: DMA reads 0x100/0x104/0x108 at N+1/N+4/N+7. PIM words (0x40,0xA0),(0x44,0xA1),(0x48,0xA2) at N+3/N+6/N+9. done_o at N+10. busy_o low at N+11.
- Zero length:
  - Stimulus: len=0.
  - Response: done_o at N+1, no DMA dmem_req_o, no pim_valid_o.
- Starvation guard:
  - Stimulus: core_req_i=1 continuously, STARVE_LIM=4, len=1.
  - Response: core granted N+1..N+4. DMA read issued at N+5 with core_gnt_o=0 only at N+5. Core granted again from N+6.
- PIM backpressure:
  - Stimulus: pim_ready_i=0 for 5 cycles in PUSH.
  - Response: pim_valid_o, pim_addr_o and pim_data_o are held stable for all 6 cycles. done_o is delayed by 5 cycles.
- Command while busy:
  - Stimulus: dma_en_i held from N+2 onward.
  - Response: stall_o=1 through the DONE cycle. The second command is accepted in the first IDLE cycle with correctly latched new operands.
- Reset mid-transfer:
  - Stimulus: rst_i for 1 cycle during the PUSH of word 2 of 4.
  - Response: all outputs at reset values the next cycle, no done_o. A new command transfers correctly from its own src.
- Address wrap:
  - Stimulus: src=0xFFFFFFFC, len=2.
  - Response: reads at 0xFFFFFFFC then 0x00000000.
